keyschedule: RTL and testbench

Sequential AES-128 key expansion. It accepts a 128-bit cipher key and generates the 11 round keys (rk0..rk10), one per clock. The keys are held in an internal register file, and a combinational read port sits directly upstream of the round datapath. The round stage reads the key for its current round index from this block, and addroundkey consumes that key.

---
 rtl/keyschedule_pkg.sv | 30 +++
 rtl/keyschedule_if.sv | 20 ++
 rtl/keyschedule_sbox.sv | 30 +++
 rtl/keyschedule.sv | 102 ++++++++++
 tb/tb_keyschedule.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/keyschedule_pkg.sv
// keyschedule_pkg: shared types and constants for the AES-128 key schedule.
//   NR_ROUNDS : number of AES-128 rounds (11 round keys rk0..rk10)
//   rkey_t    : one 128-bit round key, byte b at [127-8b -: 8]
//   state_e   : expansion FSM states
//   rcon()    : round constant for rounds 1..10, 0 elsewhere
package keyschedule_pkg;

  localparam int NR_ROUNDS = 10;

  typedef logic [127:0] rkey_t;

  typedef enum logic {IDLE, EXPAND} state_e;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/keyschedule_if.sv
// keyschedule_if: request/readback bundle of the key schedule.
//   start, key_in : expansion request (master -> slave)
//   busy, done, keys_valid : status (slave -> master)
//   rd_round -> rd_key : combinational round-key read port
interface keyschedule_if;
  import keyschedule_pkg::*;

  logic        start;
  rkey_t       key_in;
  logic        busy;
  logic        done;
  logic        keys_valid;
  logic [3:0]  rd_round;
  rkey_t       rd_key;

  modport master (output start, key_in, rd_round,
                  input  busy, done, keys_valid, rd_key);
  modport slave  (input  start, key_in, rd_round,
                  output busy, done, keys_valid, rd_key);
endinterface

// File: rtl/keyschedule_sbox.sv
// sbox: combinational AES forward S-box, one byte.
//   a : input byte
//   y : S(a)
// The single table shared by every SubWord/SubBytes user.
module sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  // Row 0 of the table sits in the top bits, so entry a lives at index ~a.
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX[~a];
endmodule

// File: rtl/keyschedule.sv
// keyschedule: sequential AES-128 key expansion, one round key per clock.
//   clk, rst : clock, synchronous active-high reset
//   bus      : keyschedule_if.slave
//              start/key_in request, busy/done/keys_valid status,
//              rd_round -> rd_key combinational read of the register file
// rk0 is loaded on the accepting edge, rk1..rkNR on the following NR edges.
module keyschedule
  import keyschedule_pkg::*;
#(
  parameter int NR = NR_ROUNDS
) (
  input  logic           clk,
  input  logic           rst,
  keyschedule_if.slave   bus
);

  state_e      state_q, state_d;
  logic [3:0]  rnd_q, rnd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        kv_q, kv_d;
  rkey_t       rk_q [0:NR];
  rkey_t       rk_d [0:NR];

  // ---- round function on rk[rnd-1] ----
  logic [3:0]  prev_idx;
  rkey_t       prev_key;
  logic [31:0] rot, sub, t, n0, n1, n2, n3;

  assign prev_idx = (rnd_q == 4'd0) ? 4'd0 : rnd_q - 4'd1;
  assign prev_key = rk_q[prev_idx];
  assign rot      = {prev_key[23:0], prev_key[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sub
    sbox u_sbox (.a(rot[8*i +: 8]), .y(sub[8*i +: 8]));
  end

  assign t  = sub ^ {rcon(rnd_q), 24'h0};
  assign n0 = prev_key[127:96] ^ t;
  assign n1 = prev_key[95:64]  ^ n0;
  assign n2 = prev_key[63:32]  ^ n1;
  assign n3 = prev_key[31:0]   ^ n2;

  // ---- FSM / register file next state ----
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    kv_d    = kv_q;
    rk_d    = rk_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          rk_d[0] = bus.key_in;
          rnd_d   = 4'd1;
          busy_d  = 1'b1;
          kv_d    = 1'b0;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        rk_d[rnd_q] = {n0, n1, n2, n3};
        if (rnd_q == 4'(NR)) begin
          rnd_d   = 4'd0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          kv_d    = 1'b1;
          state_d = IDLE;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rnd_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      kv_q    <= 1'b0;
      for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      kv_q    <= kv_d;
      for (int i = 0; i <= NR; i++) rk_q[i] <= rk_d[i];
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.keys_valid = kv_q;
  // Out-of-range indices read as zero rather than aliasing a stored key.
  assign bus.rd_key     = (bus.rd_round <= 4'(NR)) ? rk_q[bus.rd_round] : '0;

endmodule

// File: tb/tb_keyschedule.sv
// tb_keyschedule: directed checks of keyschedule against FIPS-197 vectors.
module tb_keyschedule;
  import keyschedule_pkg::*;

  localparam rkey_t K_A1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam rkey_t A1_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam rkey_t A1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam rkey_t K_ZERO  = 128'h0;
  localparam rkey_t Z_RK1   = 128'h62636363626363636263636362636363;
  localparam rkey_t Z_RK10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  keyschedule_if bus ();
  keyschedule #(.NR(10)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [3:0] r, output rkey_t k);
    bus.rd_round = r;
    #1;
    k = bus.rd_key;
  endtask

  // Accept key, then expect done exactly 10 cycles after acceptance.
  task automatic expand(input rkey_t key, input string tag);
    int lat;
    lat = 0;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.key_in = key;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.key_in = ~key;   // only the acceptance-cycle value may matter
    chk({tag, ".busy_e0"}, bus.busy, 1);
    chk({tag, ".kv_e0"}, bus.keys_valid, 0);
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (bus.done) lat = i;
    end
    chk({tag, ".latency"}, lat, 10);
    chk({tag, ".kv_done"}, bus.keys_valid, 1);
    chk({tag, ".busy_done"}, bus.busy, 0);
    @(posedge clk); #1;
    chk({tag, ".done_fall"}, bus.done, 0);
    chk({tag, ".kv_hold"}, bus.keys_valid, 1);
  endtask

  initial begin
    rkey_t k;
    int pulses, first;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.key_in = '0;
    bus.rd_round = 4'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    chk("rst.busy", bus.busy, 0);
    chk("rst.done", bus.done, 0);
    chk("rst.kv", bus.keys_valid, 0);
    rd(4'd0, k);  chk("rst.rk0", k, 0);
    rd(4'd10, k); chk("rst.rk10", k, 0);

    // FIPS-197 A.1
    expand(K_A1, "a1");
    rd(4'd1, k);  chk("a1.rk1", k, A1_RK1);
    rd(4'd10, k); chk("a1.rk10", k, A1_RK10);
    rd(4'd0, k);  chk("a1.rk0", k, K_A1);

    // all-zero key
    expand(K_ZERO, "zero");
    rd(4'd1, k);  chk("zero.rk1", k, Z_RK1);
    rd(4'd10, k); chk("zero.rk10", k, Z_RK10);
    rd(4'd0, k);  chk("zero.rk0", k, K_ZERO);

    // second start mid-expansion is ignored
    pulses = 0; first = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.key_in = K_A1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 3) begin bus.start = 1'b1; bus.key_in = K_ZERO; end
      if (i == 4) bus.start = 1'b0;
      if (bus.done) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    chk("ign.latency", first, 10);
    chk("ign.pulses", pulses, 1);
    rd(4'd1, k);  chk("ign.rk1", k, A1_RK1);
    rd(4'd10, k); chk("ign.rk10", k, A1_RK10);

    // reset at rnd=5 aborts and clears storage
    @(negedge clk);
    bus.start = 1'b1; bus.key_in = K_ZERO;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 1; i <= 4; i++) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort.busy", bus.busy, 0);
    chk("abort.kv", bus.keys_valid, 0);
    chk("abort.done", bus.done, 0);
    for (int r = 0; r < 16; r++) begin
      rd(4'(r), k);
      chk($sformatf("abort.rk%0d", r), k, 0);
    end
    expand(K_A1, "restart");
    rd(4'd1, k);  chk("restart.rk1", k, A1_RK1);
    rd(4'd10, k); chk("restart.rk10", k, A1_RK10);

    // start held high: back-to-back expansions every 11 cycles
    @(negedge clk);
    bus.start = 1'b1; bus.key_in = K_A1;
    @(posedge clk); #1;
    for (int i = 1; i <= 33; i++) begin
      @(posedge clk); #1;
      chk($sformatf("b2b.done%0d", i), bus.done, ((i % 11) == 10));
      chk($sformatf("b2b.kv%0d", i), bus.keys_valid, ((i % 11) == 10));
      rd(4'(11 + (i % 5)), k);
      chk($sformatf("b2b.oor%0d", i), k, 0);
    end
    bus.start = 1'b0;
    rd(4'd10, k); chk("b2b.rk10", k, A1_RK10);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
